// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC register and picks the next fetch address.
// Next PC comes from sequential, predicted branch/JAL, JALR wait, or an EX redirect.
// Optional BHT: define PC_CTRL_BHT_EN for 2-bit counter branch prediction (default: static BTFN).

`ifndef RESET_PC_VALUE
`define RESET_PC_VALUE 32'h0000_0000
`endif

module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = `RESET_PC_VALUE,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        stall_i,
    input  logic [31:0] if_inst_i,
    input  logic        ex_resolve_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jalr_i,
    input  logic        ex_taken_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        if_id_hold_o,
    output logic        mispredict_o
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        WAIT_JALR = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // ------------------------------------------------------------------
    // IF-stage decode of the instruction currently returned by imem
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        br_pred;
    logic        pred;

    assign opcode  = if_inst_i[6:0];
    assign is_br   = (opcode == OPC_BRANCH);
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jalr = (opcode == OPC_JALR);

    // RV32I B- and J-type immediates, sign-extended, bit 0 always zero
    assign imm_b = {{20{if_inst_i[31]}}, if_inst_i[7], if_inst_i[30:25],
                    if_inst_i[11:8], 1'b0};
    assign imm_j = {{12{if_inst_i[31]}}, if_inst_i[19:12], if_inst_i[20],
                    if_inst_i[30:21], 1'b0};

`ifdef PC_CTRL_BHT_EN
    // ------------------------------------------------------------------
    // Branch history table: 2-bit saturating counters indexed by word PC
    // ------------------------------------------------------------------
    localparam int BHT_DEPTH = 1 << BHT_IDX_W;

    logic [1:0]           bht_q [BHT_DEPTH];
    logic [BHT_IDX_W-1:0] bht_rd_idx;
    logic [BHT_IDX_W-1:0] bht_wr_idx;
    logic                 bht_upd;

    assign bht_rd_idx = pc_q[BHT_IDX_W+1:2];
    assign bht_wr_idx = ex_pc_i[BHT_IDX_W+1:2];
    // Training follows every resolved branch; stalls do not block it, a
    // disabled fetch unit does.
    assign bht_upd    = ena & ex_resolve_i & ex_is_branch_i;
    assign br_pred    = bht_q[bht_rd_idx][1];

    // Counter storage: weakly-not-taken after reset, saturating train on resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            if (ex_taken_i) begin
                if (bht_q[bht_wr_idx] != 2'b11) begin
                    bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] + 2'b01;
                end
            end else begin
                if (bht_q[bht_wr_idx] != 2'b00) begin
                    bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] - 2'b01;
                end
            end
        end
    end
`else
    // Static backward-taken / forward-not-taken: the sign of the offset decides
    assign br_pred = if_inst_i[31];

    // Inputs and parameters that only the BHT build consumes
    logic unused_no_bht;
    assign unused_no_bht = &{1'b0, ex_is_branch_i, (BHT_IDX_W > 0)};
`endif

    assign pred = (is_br & br_pred) | is_jal;

    // ------------------------------------------------------------------
    // EX resolution and redirect arithmetic (all mod 2^32)
    // ------------------------------------------------------------------
    logic        mispred;
    logic [31:0] ex_tgt;
    logic [31:0] ex_pc_plus4;
    logic [31:0] pc_plus4;
    logic [31:0] pc_pred_tgt;
    logic        unused_tgt_lsb;

    // JALR is never predicted, so it cannot mispredict; it is handled by the wait state
    assign mispred        = ex_resolve_i & ~ex_is_jalr_i & (ex_taken_i != ex_pred_taken_i);
    assign ex_tgt         = {ex_target_i[31:2], 2'b00};
    assign unused_tgt_lsb = &{1'b0, ex_target_i[1:0]};
    assign ex_pc_plus4    = ex_pc_i + 32'd4;
    assign pc_plus4       = pc_q + 32'd4;
    assign pc_pred_tgt    = pc_q + (is_jal ? imm_j : imm_b);

    // Next-PC selection and pipeline controls, highest priority first
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if_id_hold_o  = 1'b0;
        mispredict_o  = 1'b0;

        if (mispred) begin
            // Older control transfer was wrong: squash IF and ID, restart fetch.
            // Wins over stall, disable and any pending JALR (which is wrong-path).
            pc_d          = ex_taken_i ? ex_tgt : ex_pc_plus4;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            mispredict_o  = 1'b1;
            state_d       = RUN;
        end else if ((state_q == WAIT_JALR) && ex_resolve_i && ex_is_jalr_i) begin
            // JALR target now known; resume fetching there
            pc_d    = ex_tgt;
            state_d = RUN;
        end else if (stall_i || !ena) begin
            // Frozen: PC and state hold; only a hazard stall also freezes IF/ID
            if_id_hold_o = stall_i;
        end else if (state_q == WAIT_JALR) begin
            // Keep re-fetching the JALR address but feed bubbles downstream
            if_id_flush_o = 1'b1;
        end else if (is_jalr) begin
            // JALR enters IF/ID now; PC parks until EX supplies the target
            state_d = WAIT_JALR;
        end else if (pred) begin
            pc_d = pc_pred_tgt;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // PC and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc_o         = pc_q;
    assign pred_taken_o = pred;

endmodule
